// File: rtl/reg_writeback_queue.sv
// In-order writeback queue in front of the register file write port.
// Merges ALU and load results, drains one entry per cycle and offers pending-write forwarding.
module reg_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_dest,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_dest,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       stall_wb,
  output logic                       reg_write_en,
  output logic [ADDR_W-1:0]          reg_write_dest,
  output logic [DATA_W-1:0]          reg_write_data,
  input  logic [ADDR_W-1:0]          lookup_addr_1,
  output logic                       lookup_hit_1,
  output logic [DATA_W-1:0]          lookup_data_1,
  input  logic [ADDR_W-1:0]          lookup_addr_2,
  output logic                       lookup_hit_2,
  output logic [DATA_W-1:0]          lookup_data_2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  mem_ptr;
  logic [PTR_W-1:0]  idx;
  logic              alu_push, mem_push, pop;

  // Readiness looks only at the registered count; a same-cycle pop earns no credit.
  assign alu_ready = count_q < CNT_W'(DEPTH);
  assign mem_ready = alu_valid ? (count_q < CNT_W'(DEPTH-1)) : (count_q < CNT_W'(DEPTH));

  // Writes to R0 finish their handshake but are dropped here.
  assign alu_push = alu_valid & alu_ready & (alu_dest != '0);
  assign mem_push = mem_valid & mem_ready & (mem_dest != '0);
  assign mem_ptr  = wr_ptr_q + PTR_W'(alu_push);

  assign empty          = (count_q == '0);
  assign full           = (count_q == CNT_W'(DEPTH));
  assign count          = count_q;
  assign reg_write_en   = !empty & !stall_wb;
  assign reg_write_dest = dest_q[rd_ptr_q];
  assign reg_write_data = data_q[rd_ptr_q];
  assign pop            = reg_write_en;

  always_comb begin
    dest_d = dest_q;
    data_d = data_q;
    if (alu_push) begin
      dest_d[wr_ptr_q] = alu_dest;
      data_d[wr_ptr_q] = alu_data;
    end
    if (mem_push) begin
      dest_d[mem_ptr] = mem_dest;
      data_d[mem_ptr] = mem_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(alu_push) + PTR_W'(mem_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit_1  = 1'b0;
    lookup_data_1 = '0;
    lookup_hit_2  = 1'b0;
    lookup_data_2 = '0;
    idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((lookup_addr_1 != '0) && (dest_q[idx] == lookup_addr_1)) begin
          lookup_hit_1  = 1'b1;
          lookup_data_1 = data_q[idx];
        end
        if ((lookup_addr_2 != '0) && (dest_q[idx] == lookup_addr_2)) begin
          lookup_hit_2  = 1'b1;
          lookup_data_2 = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

endmodule
